// File: rtl/qspi_slave_pkg.sv
// rtl/qspi_slave_pkg.sv - shared constants and FSM state type for the QSPI slave byte engine
package qspi_slave_pkg;

  localparam int DEF_DWIDTH = 2;
  localparam int SLICES     = 8 / DEF_DWIDTH;
  localparam int CNT_W      = $clog2(SLICES);

  // ST_ARM: after reset, wait for QSS to be seen high before honouring a select
  typedef enum logic [1:0] {
    ST_ARM  = 2'd0,
    ST_IDLE = 2'd1,
    ST_SEL  = 2'd2
  } state_t;

endpackage

// File: rtl/qspi_sync_edge.sv
// rtl/qspi_sync_edge.sv - 2-FF synchroniser with history register and rise/fall detect
module qspi_sync_edge (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic hist;

  always_ff @(posedge CLK) begin
    if (RST) begin
      meta <= 1'b0;
      sync <= 1'b0;
      hist <= 1'b0;
    end else begin
      meta <= d;
      sync <= meta;
      hist <= sync;
    end
  end

  assign rise = sync & ~hist;
  assign fall = ~sync & hist;

endmodule

// File: rtl/qspi_slave_rxtx.sv
// rtl/qspi_slave_rxtx.sv - QSPI mode-0 slave byte engine: rx deserialiser and tx serialiser in the CLK domain
module qspi_slave_rxtx
  import qspi_slave_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              QSS,
  input  logic              QCK,
  input  logic [DWIDTH-1:0] QD_IN,
  output logic [DWIDTH-1:0] QD_OUT,
  output logic [7:0]        rxdata,
  output logic              rxready,
  input  logic [7:0]        txdata,
  output logic              txready
);

  localparam int NSLICE = (DWIDTH == DEF_DWIDTH) ? SLICES : 8 / DWIDTH;
  localparam int NCNT_W = (DWIDTH == DEF_DWIDTH) ? CNT_W : $clog2(8 / DWIDTH);
  localparam logic [NCNT_W-1:0] CNT_LAST = NCNT_W'(NSLICE - 1);

  logic qss_rise, qss_fall, qck_rise, qck_fall;
  logic [DWIDTH-1:0] qd_meta, qd_sync;

  state_t state, state_next;
  logic [NCNT_W-1:0] cnt;
  logic [7:0] rxshift, txshift, rx_next;
  logic tx_load, tx_shift, tx_commit, rx_take, cnt_clr;

  qspi_sync_edge u_sync_qss (.CLK(CLK), .RST(RST), .d(QSS), .rise(qss_rise), .fall(qss_fall));
  qspi_sync_edge u_sync_qck (.CLK(CLK), .RST(RST), .d(QCK), .rise(qck_rise), .fall(qck_fall));

  // Data shares the two-stage delay of QCK so it is sampled on the detected rise
  always_ff @(posedge CLK) begin
    if (RST) begin
      qd_meta <= '0;
      qd_sync <= '0;
    end else begin
      qd_meta <= QD_IN;
      qd_sync <= qd_meta;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_ARM;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    tx_load    = 1'b0;
    tx_shift   = 1'b0;
    tx_commit  = 1'b0;
    rx_take    = 1'b0;
    cnt_clr    = 1'b0;
    unique case (state)
      ST_ARM: begin
        if (qss_rise) state_next = ST_IDLE;
      end
      ST_IDLE: begin
        tx_load = 1'b1;
        cnt_clr = 1'b1;
        if (qss_fall) begin
          state_next = ST_SEL;
          tx_commit  = 1'b1;
        end
      end
      ST_SEL: begin
        // Deselect wins over any QCK edge seen in the same cycle
        if (qss_rise) begin
          state_next = ST_IDLE;
          cnt_clr    = 1'b1;
        end else if (qck_rise) begin
          rx_take = 1'b1;
        end else if (qck_fall) begin
          if (cnt == '0) begin
            tx_load   = 1'b1;
            tx_commit = 1'b1;
          end else begin
            tx_shift = 1'b1;
          end
        end
      end
      default: state_next = ST_ARM;
    endcase
  end

  assign rx_next = {rxshift[7-DWIDTH:0], qd_sync};

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt     <= '0;
      rxshift <= '0;
      txshift <= '0;
      rxdata  <= '0;
      rxready <= 1'b0;
      txready <= 1'b0;
    end else begin
      rxready <= 1'b0;
      txready <= tx_commit;
      if (cnt_clr) begin
        cnt <= '0;
      end else if (rx_take) begin
        rxshift <= rx_next;
        if (cnt == CNT_LAST) begin
          cnt     <= '0;
          rxdata  <= rx_next;
          rxready <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      if (tx_load)       txshift <= txdata;
      else if (tx_shift) txshift <= txshift << DWIDTH;
    end
  end

  assign QD_OUT = txshift[7 -: DWIDTH];

endmodule

// File: tb/tb_qspi_slave_rxtx.sv
// tb/tb_qspi_slave_rxtx.sv - randomized bench for qspi_slave_rxtx at DWIDTH 1, 2 and 4
module tb_qspi_slave_rxtx;

  localparam int HP = 6;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic [2:0] qss_v = 3'b111;
  logic [2:0] qck_v = 3'b000;
  logic [3:0] qdi [3];
  logic [7:0] txdata = 8'h00;
  logic [7:0] rxd [3];
  logic [2:0] rxr, txr;
  logic [0:0] qdo1;
  logic [1:0] qdo2;
  logic [3:0] qdo4;
  logic [3:0] qdo [3];

  assign qdo[0] = {3'b000, qdo1};
  assign qdo[1] = {2'b00, qdo2};
  assign qdo[2] = qdo4;

  qspi_slave_rxtx #(.DWIDTH(1)) u_dw1 (
    .CLK(CLK), .RST(RST), .QSS(qss_v[0]), .QCK(qck_v[0]), .QD_IN(qdi[0][0:0]), .QD_OUT(qdo1),
    .rxdata(rxd[0]), .rxready(rxr[0]), .txdata(txdata), .txready(txr[0]));
  qspi_slave_rxtx #(.DWIDTH(2)) u_dw2 (
    .CLK(CLK), .RST(RST), .QSS(qss_v[1]), .QCK(qck_v[1]), .QD_IN(qdi[1][1:0]), .QD_OUT(qdo2),
    .rxdata(rxd[1]), .rxready(rxr[1]), .txdata(txdata), .txready(txr[1]));
  qspi_slave_rxtx #(.DWIDTH(4)) u_dw4 (
    .CLK(CLK), .RST(RST), .QSS(qss_v[2]), .QCK(qck_v[2]), .QD_IN(qdi[2]), .QD_OUT(qdo4),
    .rxdata(rxd[2]), .rxready(rxr[2]), .txdata(txdata), .txready(txr[2]));

  int errs = 0;
  int checks = 0;
  int cur = 1;
  int tx_cnt = 0;
  int nslice = 0;
  logic [7:0] rx_exp [$];
  logic [7:0] tx_list [$];
  logic [2:0] rxr_d = 3'b000;
  logic [2:0] txr_d = 3'b000;
  logic [7:0] rxd_d [3];
  logic rst_d = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rnd();
    return 8'($urandom);
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Strobe monitor and host model: on each txready the host presents the next queued byte
  always @(negedge CLK) begin
    for (int i = 0; i < 3; i++) begin
      if (rxr[i]) begin
        chk("rxready_width", 32'(rxr_d[i]), 0);
        if (i != cur)              chk("rx_strobe_inst", i, cur);
        else if (rx_exp.size() == 0) chk("rx_strobe_count", rx_exp.size(), 1);
        else                       chk("rxdata", rxd[i], rx_exp.pop_front());
      end else if (!RST && !rst_d && rxd[i] != rxd_d[i]) begin
        chk("rxdata_hold", rxd[i], rxd_d[i]);
      end
      if (txr[i]) begin
        chk("txready_width", 32'(txr_d[i]), 0);
        if (i != cur) begin
          chk("tx_strobe_inst", i, cur);
        end else begin
          tx_cnt++;
          if (tx_list.size() <= tx_cnt) tx_list.push_back(rnd());
        end
      end
      rxd_d[i] = rxd[i];
    end
    rxr_d = rxr;
    txr_d = txr;
    rst_d = RST;
    txdata = (tx_cnt < tx_list.size()) ? tx_list[tx_cnt] : 8'h00;
  end

  task automatic do_select(input int i, input logic [7:0] b0, input logic [7:0] b1);
    cur = i;
    tx_list.delete();
    tx_list.push_back(b0);
    tx_list.push_back(b1);
    tx_cnt = 0;
    nslice = 0;
    rx_exp.delete();
    tick(4);
    qss_v[i] = 1'b0;
    tick(HP);
  endtask

  // Master side: drive nsl slices of b MSB first; when live, check QD_OUT against the tx byte stream
  task automatic send(input logic [7:0] b, input int nsl, input bit live);
    int w, s, m;
    logic [7:0] tb_byte;
    w = 1 << cur;
    s = 8 >> cur;
    m = (1 << w) - 1;
    if (live && nsl == s) rx_exp.push_back(b);
    for (int k = 0; k < nsl; k++) begin
      qdi[cur] = 4'((int'(b) >> (8 - w * (k + 1))) & m);
      tick(HP);
      if (live) begin
        tb_byte = tx_list[nslice / s];
        chk("qd_out", qdo[cur], (int'(tb_byte) >> (8 - w * (nslice % s + 1))) & m);
        nslice++;
      end
      qck_v[cur] = 1'b1;
      tick(HP);
      qck_v[cur] = 1'b0;
    end
  endtask

  task automatic do_deselect(input int exp_commits);
    tick(HP);
    qss_v[cur] = 1'b1;
    tick(HP);
    chk("tx_commits", tx_cnt, exp_commits);
    chk("rx_pending", rx_exp.size(), 0);
    chk("idle_qd_out", qdo[cur], int'(txdata) >> (8 - (1 << cur)));
  endtask

  initial begin
    int nb, s;
    for (int i = 0; i < 3; i++) qdi[i] = 4'h0;
    tick(3);
    for (int i = 0; i < 3; i++) begin
      chk("reset_rxdata", rxd[i], 0);
      chk("reset_rxready", 32'(rxr[i]), 0);
      chk("reset_txready", 32'(txr[i]), 0);
      chk("reset_qd_out", qdo[i], 0);
    end
    RST = 1'b0;
    tick(8);

    do_select(1, rnd(), rnd());
    send(8'hA5, 4, 1'b1);
    do_deselect(2);

    do_select(1, rnd(), rnd());
    send(8'h01, 4, 1'b1);
    send(8'h0F, 4, 1'b1);
    send(8'hFF, 4, 1'b1);
    do_deselect(4);

    do_select(1, 8'h3C, 8'h81);
    send(rnd(), 4, 1'b1);
    send(rnd(), 4, 1'b1);
    do_deselect(3);

    do_select(1, rnd(), rnd());
    send(rnd(), 2, 1'b1);
    do_deselect(1);
    do_select(1, rnd(), rnd());
    send(8'h7E, 4, 1'b1);
    do_deselect(2);

    do_select(1, rnd(), rnd());
    send(rnd(), 2, 1'b1);
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    chk("rst_mid_rxdata", rxd[1], 0);
    chk("rst_mid_qd_out", qdo[1], 0);
    tx_cnt = 0;
    rx_exp.delete();
    send(rnd(), 4, 1'b0);
    tick(HP);
    chk("rst_quiet_tx", tx_cnt, 0);
    chk("rst_quiet_rxdata", rxd[1], 0);
    qss_v[1] = 1'b1;
    tick(HP);
    do_select(1, rnd(), rnd());
    send(8'h55, 4, 1'b1);
    do_deselect(2);

    do_select(0, 8'hC3, rnd());
    send(8'hC3, 8, 1'b1);
    send(rnd(), 8, 1'b1);
    do_deselect(3);
    do_select(2, 8'hC3, rnd());
    send(8'hC3, 2, 1'b1);
    send(rnd(), 2, 1'b1);
    do_deselect(3);

    for (int n = 0; n < 9; n++) begin
      s = 8 >> (n % 3);
      do_select(n % 3, rnd(), rnd());
      nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) send(rnd(), s, 1'b1);
      if ($urandom_range(0, 3) == 0) send(rnd(), $urandom_range(1, s - 1), 1'b1);
      do_deselect(nb + 1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
